// File: rtl/vli_decoder_if.sv
// Bundle for the JPEG variable-length-integer decoder: raw SSSS/bits in,
// combinational and registered coefficient plus status out.
interface vli_decoder_if;
  logic [3:0]         size;
  logic [10:0]        symbol;
  logic               in_valid;
  logic signed [11:0] value;
  logic signed [11:0] value_r;
  logic               out_valid;
  logic               err;

  modport master (
    output size, symbol, in_valid,
    input  value, value_r, out_valid, err
  );

  modport slave (
    input  size, symbol, in_valid,
    output value, value_r, out_valid, err
  );
endinterface

// File: rtl/vli_decoder.sv
// JPEG VLI decoder: combinational SSSS/bits -> signed coefficient, plus a one-cycle
// registered copy. Optional macro VLI_MASK_SYMBOL_EN clears symbol bits at/above size.
module vli_decoder (
  input  logic         clk,
  input  logic         reset,
  vli_decoder_if.slave bus
);

  localparam logic [3:0] MaxSize = 4'd11;

  logic               size_legal;
  logic               size_zero;
  logic [11:0]        offset;     // 2^size - 1
  logic [10:0]        sign_mask;  // one-hot at bit size-1
  logic [10:0]        sym_eff;
  logic               sign_bit;
  logic signed [11:0] value_d;

  logic signed [11:0] value_r_q;
  logic               out_valid_q;
  logic               err_q;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // value on every path, so no latch can be inferred.
  always_comb begin
    size_legal = (bus.size <= MaxSize);
    size_zero  = (bus.size == 4'd0);
    offset     = (12'd1 << bus.size) - 12'd1;
    // x ^ (x >> 1) isolates the top set bit of a 2^k-1 mask.
    sign_mask  = offset[10:0] ^ (offset[10:0] >> 1);
`ifdef VLI_MASK_SYMBOL_EN
    sym_eff    = bus.symbol & offset[10:0];
`else
    sym_eff    = bus.symbol;
`endif
    sign_bit   = |(bus.symbol & sign_mask);

    value_d = '0;
    if (size_legal && !size_zero) begin
      if (sign_bit) begin
        value_d = signed'({1'b0, sym_eff});
      end else begin
        value_d = signed'({1'b0, sym_eff} - offset);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      err_q       <= bus.in_valid & ~size_legal;
      if (bus.in_valid) begin
        value_r_q <= value_d;
      end
    end
  end

  assign bus.value     = value_d;
  assign bus.value_r   = value_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_vli_decoder.sv
// Self-checking bench for vli_decoder: inline combinational checks plus a scoreboard
// queue matched against the registered outputs one cycle later.
module tb_vli_decoder;

  typedef struct {
    logic signed [11:0] value;
    logic               err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  vli_decoder_if bus ();

  vli_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t               sb_q[$];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  logic signed [11:0] hold_val = '0;

  // Independent reference: plain integer arithmetic on the nominal JPEG rule.
  function automatic int ref_value(input int sz, input int sym);
    if (sz == 0 || sz > 11) return 0;
    if (((sym >> (sz - 1)) & 1) == 1) return sym;
    return sym - ((1 << sz) - 1);
  endfunction

  // Registered-side check, run at the negedge after the capturing posedge.
  task automatic check_registered(input string tag, input logic vld);
    exp_t e;
    n_cmp++;
    if (bus.out_valid !== vld) begin
      n_bad++;
      $display("FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, vld);
    end
    if (vld) begin
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      end else begin
        e = sb_q.pop_front();
        hold_val = e.value;
        n_cmp++;
        if (bus.value_r !== e.value) begin
          n_bad++;
          $display("FAIL %s value_r: got %0d expected %0d", tag, bus.value_r, e.value);
        end
        n_cmp++;
        if (bus.err !== e.err) begin
          n_bad++;
          $display("FAIL %s err: got %b expected %b", tag, bus.err, e.err);
        end
      end
    end else begin
      n_cmp++;
      if (bus.value_r !== hold_val) begin
        n_bad++;
        $display("FAIL %s value_r hold: got %0d expected %0d", tag, bus.value_r, hold_val);
      end
      n_cmp++;
      if (bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s err idle: got %b expected 0", tag, bus.err);
      end
    end
  endtask

  // One cycle: present inputs (called just after a negedge), check value, queue
  // the registered expectation, then check registered outputs after the edge.
  task automatic step(input logic [3:0] sz, input logic [10:0] sym, input logic vld,
                      input int exp_val, input string tag);
    exp_t e;
    bus.size     = sz;
    bus.symbol   = sym;
    bus.in_valid = vld;
    #1;
    n_cmp++;
    if (bus.value !== 12'(exp_val)) begin
      n_bad++;
      $display("FAIL %s value: got %0d expected %0d", tag, bus.value, exp_val);
    end
    if (vld) begin
      e.value = 12'(exp_val);
      e.err   = (sz > 4'd11);
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_registered(tag, vld);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.size     = 4'd1;
    bus.symbol   = 11'd1;
    bus.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.value_r !== 12'sd0) begin
      n_bad++;
      $display("FAIL reset_state: got ov=%b err=%b vr=%0d expected 0/0/0",
               bus.out_valid, bus.err, bus.value_r);
    end
    n_cmp++;
    if (bus.value !== 12'sd1) begin
      n_bad++;
      $display("FAIL reset_comb_value: got %0d expected 1", bus.value);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.value_r !== 12'sd0) begin
      n_bad++;
      $display("FAIL reset_held: got ov=%b vr=%0d expected 0/0", bus.out_valid, bus.value_r);
    end
    // Input presented in the cycle reset drops must be captured.
    reset = 1'b0;
    step(4'd1, 11'd1, 1'b1, 1, "reset_release_capture");
  endtask

  task automatic test_decode_table();
    logic [3:0]  sz_t [10] = '{4'd3, 4'd0, 4'd0, 4'd1, 4'd1, 4'd10, 4'd11, 4'd11, 4'd5, 4'd6};
    logic [10:0] sym_t[10] = '{11'h007, 11'h7FF, 11'h155, 11'h001, 11'h000,
                               11'h000, 11'h000, 11'h7FF, 11'h00A, 11'h020};
    int          exp_t_[10] = '{7, 0, 0, 1, -1, -1023, -2047, 2047, -21, 32};
    for (int i = 0; i < 10; i++) begin
      step(sz_t[i], sym_t[i], 1'b1, exp_t_[i], $sformatf("decode[%0d]", i));
    end
  endtask

  task automatic test_symbol_mask();
`ifdef VLI_MASK_SYMBOL_EN
    step(4'd3, 11'b11000, 1'b1, -7, "mask_11000");
    step(4'd3, 11'b11111, 1'b1,  7, "mask_11111");
    step(4'd3, 11'b10101, 1'b1,  5, "mask_10101");
`else
    // Unmasked build decodes the full symbol; sign still comes from bit size-1.
    step(4'd3, 11'b11111, 1'b1, 31, "nomask_11111");
    step(4'd3, 11'b11000, 1'b1, 17, "nomask_11000");
`endif
  endtask

  task automatic test_err();
    step(4'd13, 11'h5A5, 1'b1, 0, "err_size13");
    step(4'd15, 11'h7FF, 1'b0, 0, "err_needs_valid");
    step(4'd12, 11'h001, 1'b1, 0, "err_size12");
    step(4'd11, 11'h400, 1'b1, 1024, "err_clear_size11");
  endtask

  task automatic test_back_to_back();
    step(4'd4, 11'b0110, 1'b1, -9, "b2b_first");
    step(4'd2, 11'b10,   1'b1,  2, "b2b_second");
    step(4'd2, 11'b01,   1'b0, -2, "b2b_idle_hold");
  endtask

  task automatic test_random();
    int sz;
    int sym;
    for (int i = 0; i < 30; i++) begin
      sz  = $urandom_range(0, 11);
      sym = (sz == 0) ? $urandom_range(0, 2047) : $urandom_range(0, (1 << sz) - 1);
      step(4'(sz), 11'(sym), 1'b1, ref_value(sz, sym), $sformatf("rand[%0d]", i));
    end
  endtask

  task automatic test_async_reset();
    step(4'd5, 11'b10000, 1'b1, 16, "areset_prime");
    // We sit at a negedge with out_valid=1; a new valid input is pending.
    bus.size     = 4'd6;
    bus.symbol   = 11'h3F;
    bus.in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.value_r !== 12'sd0) begin
      n_bad++;
      $display("FAIL async_reset: got ov=%b err=%b vr=%0d expected 0/0/0",
               bus.out_valid, bus.err, bus.value_r);
    end
    sb_q.delete();
    hold_val = '0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.value_r !== 12'sd0) begin
      n_bad++;
      $display("FAIL async_reset_drop: got ov=%b vr=%0d expected 0/0", bus.out_valid, bus.value_r);
    end
    reset = 1'b0;
    step(4'd6, 11'h3F, 1'b1, 63, "areset_release_capture");
    step(4'd6, 11'h00, 1'b0, -63, "areset_idle");
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_symbol_mask();
    test_err();
    test_back_to_back();
    test_random();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
